// File: rtl/im_loader.sv
// im_loader: writer side of the instruction memory.
// Accepts a byte stream made of a 16-bit big-endian word count, then that
// many 32-bit big-endian words, then an XOR checksum byte. Each assembled
// word is written to the instruction memory with a single-cycle strobe.
// The CPU is held off (cpu_hold=1) until a load completes with a matching
// checksum. im_addr is a word index; the matching byte address in the CPU
// map is 32'h00003000 + 4*im_addr.
// All outputs come straight from flops. Each one is loaded from the state
// the FSM is about to enter, so it is valid for the whole time the FSM is
// in that state.
module im_loader #(
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // Capacity limit, compared in 17 bits so that a count of exactly
    // DEPTH_WORDS is accepted.
    localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W:0]   idx_q, idx_d;        // one extra bit: never wraps
    logic [7:0]        csum_q, csum_d;
    logic [1:0]        lane_q, lane_d;      // byte position inside the word
    logic [23:0]       word_q, word_d;      // first three bytes of the word
    logic              in_ready_q, in_ready_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              take_s;
    logic [15:0]       hdr_count_s;
    logic [15:0]       idx_ext_s;
    logic              last_word_s;

    assign take_s      = in_valid & in_ready_q;
    assign hdr_count_s = {count_q[15:8], in_data};
    assign idx_ext_s   = 16'(idx_q);
    assign last_word_s = (idx_ext_s == (count_q - 16'd1));

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        lane_d     = lane_q;
        word_d     = word_q;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HDR_HI;
                    count_d = 16'd0;
                    idx_d   = '0;
                    csum_d  = 8'd0;
                    lane_d  = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR_HI: begin
                if (take_s) begin
                    count_d[15:8] = in_data;
                    csum_d        = csum_q ^ in_data;
                    state_d       = ST_HDR_LO;
                end else begin
                    state_d = ST_HDR_HI;
                end
            end
            ST_HDR_LO: begin
                if (take_s) begin
                    count_d[7:0] = in_data;
                    csum_d       = csum_q ^ in_data;
                    lane_d       = 2'd0;
                    if (hdr_count_s == 16'd0) begin
                        state_d = ST_CSUM;
                    end else if ({1'b0, hdr_count_s} > DEPTH_LIMIT) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_DATA: begin
                if (take_s) begin
                    csum_d = csum_q ^ in_data;
                    word_d = {word_q[15:0], in_data};
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        // Fourth byte completes the word: present it in WRITE.
                        im_addr_d  = idx_q[ADDR_W-1:0];
                        im_wdata_d = {word_q, in_data};
                        state_d    = ST_WRITE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
                    state_d = ST_CSUM;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (take_s) begin
                    if (in_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR_HI;
                    count_d = 16'd0;
                    idx_d   = '0;
                    csum_d  = 8'd0;
                    lane_d  = 2'd0;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) ||
                     (state_d == ST_DATA)   || (state_d == ST_CSUM);
        im_we_d    = (state_d == ST_WRITE);
        cpu_hold_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
    end

    // State, datapath and output registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= 16'd0;
            idx_q      <= '0;
            csum_q     <= 8'd0;
            lane_q     <= 2'd0;
            word_q     <= 24'd0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            in_ready_q <= in_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: a stream-level reference model queues the
// expected memory writes and final outcome; a monitor pops writes as the DUT
// strobes im_we.
module tb_im_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [11:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    typedef logic [7:0] bq_t[$];

    logic [43:0] sb[$];          // expected writes {addr, data}
    int          n_cmp = 0;
    int          n_bad = 0;

    im_loader #(.DEPTH_WORDS(4096), .ADDR_W(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr, im_wdata);
            end else begin
                logic [43:0] e;
                e = sb.pop_front();
                chk("write_addr", {20'd0, im_addr}, {20'd0, e[43:32]});
                chk("write_data", im_wdata, e[31:0]);
                chk("in_ready_during_write", {31'd0, in_ready}, 32'd0);
            end
        end
    end

    // Reference model: derives the writes and the verdict from the stream rules.
    task automatic model(input bq_t b, output int used, output bit ok);
        int         cnt;
        logic [7:0] x;
        cnt = (int'(b[0]) << 8) | int'(b[1]);
        if (cnt > 4096) begin
            used = 2;
            ok   = 1'b0;
        end else begin
            used = 2 + 4 * cnt + 1;
            x    = 8'd0;
            for (int i = 0; i < used - 1; i++) x = x ^ b[i];
            ok = (b[used-1] == x);
            for (int w = 0; w < cnt; w++)
                sb.push_back({12'(w), b[2+4*w], b[3+4*w], b[4+4*w], b[5+4*w]});
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        start    = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sb.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_im_we"},    {31'd0, im_we},    32'd0);
        chk({tag, "_im_addr"},  {20'd0, im_addr},  32'd0);
        chk({tag, "_im_wdata"}, im_wdata,          32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_err"},      {31'd0, err},      32'd0);
    endtask

    // Present one byte (called at a negedge) until it is taken, then optional gap.
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit got;
        int g;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 200; t++) begin
            if (in_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_accept_timeout: got no in_ready expected acceptance of %h", b);
        end
        @(negedge clk);
        g = $urandom_range(maxgap, 0);
        if (g > 0) begin
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input string tag, input bq_t b, input int maxgap);
        int used;
        bit ok;
        model(b, used, ok);
        start_pulse();
        for (int i = 0; i < used; i++) send_byte(b[i], maxgap);
        in_valid = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (done === 1'b1 || err === 1'b1) break;
            @(negedge clk);
        end
        chk({tag, "_done"},     {31'd0, done},     {31'd0, ok});
        chk({tag, "_err"},      {31'd0, err},      {31'd0, !ok});
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !ok});
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_writes_left"}, sb.size(), 32'd0);
    endtask

    // Builds a stream with cnt random words; optionally corrupts the checksum.
    task automatic gen_stream(input int cnt, input bit corrupt, output bq_t b);
        logic [7:0] x;
        logic [7:0] r;
        b = {};
        b.push_back(8'(cnt >> 8));
        b.push_back(8'(cnt));
        for (int i = 0; i < 4 * cnt; i++) begin
            r = 8'($urandom_range(255, 0));
            b.push_back(r);
        end
        x = 8'd0;
        foreach (b[i]) x = x ^ b[i];
        if (corrupt) x = x ^ 8'($urandom_range(255, 1));
        b.push_back(x);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t s1, s2, s3, s4, sp, rb;
        s1 = '{8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h32};
        s2 = '{8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h33};
        s3 = '{8'h00, 8'h00, 8'h00};
        s4 = '{8'h10, 8'h01};
        sp = '{8'h00, 8'h02, 8'h34, 8'h08};

        in_valid = 1'b0;
        in_data  = 8'd0;
        start    = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;
        @(negedge clk);

        // Basic load, then start in DONE must be ignored.
        run_load("basic", s1, 0);
        start_pulse();
        repeat (3) @(negedge clk);
        chk("done_sticky", {31'd0, done}, 32'd1);
        chk("done_no_ready", {31'd0, in_ready}, 32'd0);

        // Bad checksum, then retry from ERR.
        do_reset();
        run_load("badcsum", s2, 0);
        repeat (3) @(negedge clk);
        chk("err_no_ready", {31'd0, in_ready}, 32'd0);
        run_load("retry", s1, 0);

        // Empty load.
        do_reset();
        run_load("empty", s3, 0);

        // Oversize count, then a bad-checksum load, then reset mid-DATA.
        do_reset();
        run_load("oversize", s4, 0);
        run_load("badcsum2", s2, 0);
        start_pulse();
        for (int i = 0; i < sp.size(); i++) send_byte(sp[i], 0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        chk("idle_no_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        run_load("after_reset", s1, 0);

        // Gaps between bytes, bytes presented during WRITE.
        do_reset();
        run_load("gaps", s1, 3);

        // Randomized loads.
        for (int k = 0; k < 10; k++) begin
            do_reset();
            if ($urandom_range(4, 0) == 0) begin
                rb = {};
                rb.push_back(8'h10);
                rb.push_back(8'($urandom_range(255, 1)));
                run_load("rand_over", rb, 2);
            end else begin
                gen_stream($urandom_range(6, 0), ($urandom_range(2, 0) == 0), rb);
                run_load("rand", rb, 3);
            end
        end

        // Full-capacity load: count == DEPTH_WORDS is legal, last index 4095.
        do_reset();
        gen_stream(4096, 1'b0, rb);
        run_load("full", rb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
